// File: rtl/kamus_ex_mdu.sv
// Iterative RV32M multiply/divide unit for the kamus execute stage.
// Shift-add multiply and restoring divide on operand magnitudes, UNROLL bits per cycle.
module kamus_ex_mdu #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o,
  output logic            busy_o
);

  localparam int ITERS = XLEN / UNROLL;
  localparam int CW    = $clog2(ITERS);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;

  logic [2:0]        op_q;
  logic              neg_res, neg_rem;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] acc, acc_step, prod_fix;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   result_q;
  logic [4:0]        rd_q;

  logic              is_div, a_signed, b_signed, a_neg, b_neg;
  logic [XLEN:0]     a_ext, b_ext;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, div_ovf, fast, accept;
  logic [XLEN-1:0]   fast_res, calc_res, quo, rem;
  logic [XLEN:0]     sum, shifted, diff;

  // Incoming operation decode, fast-path detection and magnitudes
  always_comb begin
    is_div   = op_i[2];
    a_signed = (op_i == 3'd1) || (op_i == 3'd2) || (op_i == 3'd4) || (op_i == 3'd6);
    b_signed = (op_i == 3'd1) || (op_i == 3'd4) || (op_i == 3'd6);
    a_neg    = a_signed && rs1_data_i[XLEN-1];
    b_neg    = b_signed && rs2_data_i[XLEN-1];
    a_ext    = {(XLEN+1){1'b0}} - {1'b0, rs1_data_i};
    b_ext    = {(XLEN+1){1'b0}} - {1'b0, rs2_data_i};
    a_mag    = a_neg ? a_ext[XLEN-1:0] : rs1_data_i;
    b_mag    = b_neg ? b_ext[XLEN-1:0] : rs2_data_i;
    div_zero = is_div && (rs2_data_i == '0);
    div_ovf  = is_div && !op_i[0] && (rs1_data_i == MOST_NEG) && (rs2_data_i == '1);
    fast     = div_zero || div_ovf;
    if (div_zero) fast_res = op_i[1] ? rs1_data_i : '1;
    else          fast_res = op_i[1] ? '0 : rs1_data_i;
    accept   = in_valid_i && (state == IDLE) && !flush_i;
  end

  // One cycle of iteration: acc holds {high/remainder, low/quotient-in-progress}
  always_comb begin
    acc_step = acc;
    sum      = '0;
    shifted  = '0;
    diff     = '0;
    for (int unsigned i = 0; i < UNROLL; i++) begin
      if (!op_q[2]) begin
        sum      = {1'b0, acc_step[2*XLEN-1:XLEN]} + (acc_step[0] ? {1'b0, opnd} : '0);
        acc_step = {sum, acc_step[XLEN-1:1]};
      end else begin
        shifted = acc_step[2*XLEN-1:XLEN-1];
        diff    = shifted - {1'b0, opnd};
        if (!diff[XLEN]) acc_step = {diff[XLEN-1:0], acc_step[XLEN-2:0], 1'b1};
        else             acc_step = {shifted[XLEN-1:0], acc_step[XLEN-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    prod_fix = neg_res ? ({(2*XLEN){1'b0}} - acc_step) : acc_step;
    quo      = acc_step[XLEN-1:0];
    rem      = acc_step[2*XLEN-1:XLEN];
    if (op_q[2]) begin
      if (op_q[1]) calc_res = neg_rem ? ('0 - rem) : rem;
      else         calc_res = neg_res ? ('0 - quo) : quo;
    end else begin
      calc_res = (op_q[1:0] == 2'd0) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = fast ? DONE : CALC;
      CALC: if (cnt == '0) state_nxt = DONE;
      DONE: if (out_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush_i) state_nxt = IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      op_q     <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      opnd     <= '0;
      acc      <= '0;
      cnt      <= '0;
      result_q <= '0;
      rd_q     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q    <= op_i;
        rd_q    <= rd_addr_i;
        neg_res <= a_neg ^ b_neg;
        neg_rem <= a_neg;
        opnd    <= is_div ? b_mag : a_mag;
        acc     <= is_div ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
        cnt     <= CW'(ITERS - 1);
        if (fast) result_q <= fast_res;
      end else if (state == CALC && !flush_i) begin
        acc <= acc_step;
        cnt <= cnt - 1'b1;
        if (cnt == '0) result_q <= calc_res;
      end
    end
  end

  assign in_ready_o  = (state == IDLE);
  assign busy_o      = (state != IDLE);
  assign out_valid_o = (state == DONE);
  assign result_o    = result_q;
  assign rd_addr_o   = rd_q;

endmodule

// File: tb/tb_kamus_ex_mdu.sv
// Bench for kamus_ex_mdu: a 32-bit/radix-2 and a 16-bit/UNROLL=4 instance side by side,
// vector tables, random ops against an arithmetic model, and flush/backpressure/reset sequences.
module tb_kamus_ex_mdu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        sel = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic [4:0]  rd = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_valid_a, ready_a, valid_a, busy_a;
  logic [31:0] result_a;
  logic [4:0]  rd_a;
  logic        in_valid_b, ready_b, valid_b, busy_b;
  logic [15:0] result_b;
  logic [4:0]  rd_b;

  logic        cur_ready, cur_valid, cur_busy;
  logic [31:0] cur_result;
  logic [4:0]  cur_rd;

  int checks = 0;
  int errors = 0;
  logic [36:0] q_a[$];
  logic [36:0] q_b[$];
  logic [36:0] ea, eb;

  always #5 clk = ~clk;

  assign in_valid_a = in_valid && !sel;
  assign in_valid_b = in_valid && sel;
  assign cur_ready  = sel ? ready_b : ready_a;
  assign cur_valid  = sel ? valid_b : valid_a;
  assign cur_busy   = sel ? busy_b : busy_a;
  assign cur_result = sel ? {16'h0, result_b} : result_a;
  assign cur_rd     = sel ? rd_b : rd_a;

  kamus_ex_mdu #(.XLEN(32), .UNROLL(1)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid_a), .in_ready_o(ready_a),
    .op_i(op), .rs1_data_i(rs1), .rs2_data_i(rs2), .rd_addr_i(rd), .flush_i(flush),
    .out_valid_o(valid_a), .out_ready_i(out_ready), .result_o(result_a),
    .rd_addr_o(rd_a), .busy_o(busy_a)
  );

  kamus_ex_mdu #(.XLEN(16), .UNROLL(4)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid_b), .in_ready_o(ready_b),
    .op_i(op), .rs1_data_i(rs1[15:0]), .rs2_data_i(rs2[15:0]), .rd_addr_i(rd), .flush_i(flush),
    .out_valid_o(valid_b), .out_ready_i(out_ready), .result_o(result_b),
    .rd_addr_o(rd_b), .busy_o(busy_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard: results are popped and compared as they are consumed
  always @(negedge clk) begin
    if (!rst && valid_a && out_ready) begin
      if (q_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL out_a_unexpected actual=%h required=none", result_a);
      end else begin
        ea = q_a.pop_front();
        chk("result_a", result_a, ea[31:0]);
        chk("rd_a", {27'h0, rd_a}, {27'h0, ea[36:32]});
      end
    end
    if (!rst && valid_b && out_ready) begin
      if (q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL out_b_unexpected actual=%h required=none", result_b);
      end else begin
        eb = q_b.pop_front();
        chk("result_b", {16'h0, result_b}, eb[31:0]);
        chk("rd_b", {27'h0, rd_b}, {27'h0, eb[36:32]});
      end
    end
  end

  function automatic logic [31:0] model(input int w, input logic [2:0] o,
                                        input logic [31:0] a, input logic [31:0] b);
    logic [63:0] mask, au, bu, p;
    longint sa, sb, la, lb, q, r;
    mask = (64'd1 << w) - 64'd1;
    au = {32'h0, a} & mask;
    bu = {32'h0, b} & mask;
    sa = au[w-1] ? longint'(au) - longint'(64'd1 << w) : longint'(au);
    sb = bu[w-1] ? longint'(bu) - longint'(64'd1 << w) : longint'(bu);
    if (!o[2]) begin
      la = (o == 3'd1 || o == 3'd2) ? sa : longint'(au);
      lb = (o == 3'd1) ? sb : longint'(bu);
      p  = 64'(la * lb);
      return (o == 3'd0) ? 32'(p & mask) : 32'((p >> w) & mask);
    end
    if (bu == 64'd0) return o[1] ? 32'(au) : 32'(mask);
    if (!o[0]) begin
      if (au == (64'd1 << (w - 1)) && bu == mask) return o[1] ? 32'd0 : 32'(au);
      q = sa / sb;
      r = sa % sb;
      p = o[1] ? 64'(r) : 64'(q);
      return 32'(p & mask);
    end
    return o[1] ? 32'(au % bu) : 32'(au / bu);
  endfunction

  function automatic int cycle_of(input int w, input logic [2:0] o,
                                  input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mask, au, bu;
    mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    au = a & mask;
    bu = b & mask;
    if (o[2] && bu == 32'd0) return 1;
    if (o[2] && !o[0] && au == (32'd1 << (w - 1)) && bu == mask) return 1;
    return (w == 32) ? 33 : 5;
  endfunction

  // Called at posedge+1 with the selected unit idle; leaves the bench at accept edge+1
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] r, input logic push, input logic [31:0] exp);
    chk("in_ready_before_accept", {31'h0, cur_ready}, 32'd1);
    op = o; rs1 = a; rs2 = b; rd = r; in_valid = 1'b1;
    @(posedge clk);
    if (push) begin
      if (sel) q_b.push_back({r, exp});
      else     q_a.push_back({r, exp});
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int cyc);
    int n = 0;
    while (!cur_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_valid_cycle"}, 32'(n + 1), 32'(cyc));
  endtask

  task automatic run_vec(input string name, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] r,
                         input logic [31:0] exp, input int cyc);
    issue(o, a, b, r, 1'b1, exp);
    wait_valid(name, cyc);
    @(posedge clk); #1;
    chk({name, "_idle_after"}, {31'h0, cur_ready}, 32'd1);
  endtask

  task automatic seq_backpressure(input int cyc);
    out_ready = 1'b0;
    issue(3'd5, 32'd100, 32'd7, 5'd9, 1'b1, 32'd14);
    wait_valid("bp", cyc);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_valid_held", {31'h0, cur_valid}, 32'd1);
      chk("bp_result_stable", cur_result, 32'd14);
      chk("bp_rd_stable", {27'h0, cur_rd}, 32'd9);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_after", {31'h0, cur_ready}, 32'd1);
  endtask

  task automatic seq_flush(input int cyc);
    int seen = 0;
    issue(3'd0, 32'd123, 32'd456, 5'd3, 1'b0, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("flush_busy_mid_calc", {31'h0, cur_busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_idle_next", {31'h0, cur_ready}, 32'd1);
    chk("flush_busy_low", {31'h0, cur_busy}, 32'd0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (cur_valid) seen++;
    end
    chk("flush_no_valid_pulse", 32'(seen), 32'd0);
    @(posedge clk); #1;
    // A request alongside flush in IDLE must be ignored
    op = 3'd0; rs1 = 32'd9; rs2 = 32'd9; rd = 5'd4; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_blocks_accept", {31'h0, cur_busy}, 32'd0);
    run_vec("flush_then_mul", 3'd0, 32'd3, 32'd5, 5'd5, 32'd15, cyc);
  endtask

  task automatic seq_reset();
    issue(3'd4, 32'd1000, 32'd3, 5'd7, 1'b0, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_busy_mid_calc", {31'h0, cur_busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_valid", {31'h0, cur_valid}, 32'd0);
    chk("rst_async_ready", {31'h0, cur_ready}, 32'd1);
    chk("rst_async_busy", {31'h0, cur_busy}, 32'd0);
    chk("rst_async_result", cur_result, 32'd0);
    chk("rst_async_rd", {27'h0, cur_rd}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          cyc;
  } vec_t;

  vec_t va[16];
  vec_t vb[12];

  initial begin
    logic [2:0]  o;
    logic [31:0] a, b;

    va[0]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    va[1]  = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33};
    va[2]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33};
    va[3]  = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33};
    va[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
    va[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
    va[6]  = '{3'd5, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 1};
    va[7]  = '{3'd7, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 1};
    va[8]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    va[9]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    va[10] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33};
    va[11] = '{3'd4, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
    va[12] = '{3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33};
    va[13] = '{3'd6, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 1};
    va[14] = '{3'd0, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 33};
    va[15] = '{3'd5, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 33};

    vb[0]  = '{3'd3, 32'hFFFF, 32'hFFFF, 32'hFFFE, 5};
    vb[1]  = '{3'd0, 32'hFFFF, 32'hFFFF, 32'h0001, 5};
    vb[2]  = '{3'd1, 32'hFFFF, 32'hFFFF, 32'h0000, 5};
    vb[3]  = '{3'd2, 32'hFFFF, 32'hFFFF, 32'hFFFF, 5};
    vb[4]  = '{3'd4, 32'hFFF9, 32'h0002, 32'hFFFD, 5};
    vb[5]  = '{3'd6, 32'hFFF9, 32'h0002, 32'hFFFF, 5};
    vb[6]  = '{3'd5, 32'h0007, 32'h0000, 32'hFFFF, 1};
    vb[7]  = '{3'd7, 32'h0007, 32'h0000, 32'h0007, 1};
    vb[8]  = '{3'd4, 32'h8000, 32'hFFFF, 32'h8000, 1};
    vb[9]  = '{3'd6, 32'h8000, 32'hFFFF, 32'h0000, 1};
    vb[10] = '{3'd7, 32'h8000, 32'hFFFF, 32'h8000, 5};
    vb[11] = '{3'd0, 32'h0003, 32'h0005, 32'h000F, 5};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready_a", {31'h0, ready_a}, 32'd1);
    chk("reset_valid_a", {31'h0, valid_a}, 32'd0);
    chk("reset_busy_a", {31'h0, busy_a}, 32'd0);
    chk("reset_result_a", result_a, 32'd0);
    chk("reset_rd_a", {27'h0, rd_a}, 32'd0);
    chk("reset_ready_b", {31'h0, ready_b}, 32'd1);
    chk("reset_valid_b", {31'h0, valid_b}, 32'd0);
    chk("reset_result_b", {16'h0, result_b}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      if (!sel) begin
        for (int i = 0; i < $size(va); i++)
          run_vec("vec_a", va[i].op, va[i].a, va[i].b, 5'(i + 1), va[i].exp, va[i].cyc);
      end else begin
        for (int i = 0; i < $size(vb); i++)
          run_vec("vec_b", vb[i].op, vb[i].a, vb[i].b, 5'(i + 1), vb[i].exp, vb[i].cyc);
      end
      for (int i = 0; i < 24; i++) begin
        o = 3'($urandom_range(0, 7));
        a = $urandom;
        b = (i % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        if (sel) begin
          a = a & 32'hFFFF;
          b = b & 32'hFFFF;
        end
        run_vec("rand", o, a, b, 5'($urandom_range(0, 31)),
                model(sel ? 16 : 32, o, a, b), cycle_of(sel ? 16 : 32, o, a, b));
      end
      seq_backpressure(sel ? 5 : 33);
      seq_flush(sel ? 5 : 33);
      seq_reset();
    end

    repeat (3) @(posedge clk);
    chk("queue_a_drained", 32'(q_a.size()), 32'd0);
    chk("queue_b_drained", 32'(q_b.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
